// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: per-digit segment patterns (active-high, {g,f,e,d,c,b,a})
// and the hex-to-segment lookup used by every decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Unknown inputs fall to the default branch so the digit blanks instead of showing X.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/b27s_dec.sv
// Combinational hex digit to active-high segment pattern.
module b27s_dec
  import seg7_pkg::*;
(
  input  logic [3:0] sw,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(sw);

endmodule

// File: rtl/b27s.sv
// Binary-to-7-segment driver: decodes sw, applies segment polarity and (optionally)
// registers the result; reset blanks the digit asynchronously.
module b27s
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit REG_OUT    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  output logic [6:0] led
);

  localparam logic [6:0] LED_BLANK = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [6:0] seg;
  logic [6:0] drive;

  b27s_dec u_dec (
    .sw  (sw),
    .seg (seg)
  );

  assign drive = ACTIVE_LOW ? ~seg : seg;

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) led <= LED_BLANK;
        else     led <= drive;
      end
    end else begin : g_comb
      // Combinational build still honours reset so the digit blanks during reset.
      assign led = rst ? LED_BLANK : drive;
    end
  endgenerate

endmodule

// File: tb/tb_b27s.sv
// Self-checking bench for b27s: spec decode table walk, timing corner cases,
// and randomized traffic against a segment-name reference model.
module tb_b27s;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [6:0] led;
  logic [6:0] led_hi;

  int checks = 0;
  int errors = 0;

  b27s #(.ACTIVE_LOW(1'b1), .REG_OUT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .led (led)
  );

  b27s #(.ACTIVE_LOW(1'b0), .REG_OUT(1'b1)) dut_hi (
    .clk (clk),
    .rst (rst),
    .sw  (sw),
    .led (led_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[16];

  // Lit segments per digit, by segment letter.
  string lit_names[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                           "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] model(input logic [3:0] v, input bit active_low);
    logic [6:0] lit;
    string s;
    int idx;
    lit = '0;
    s = lit_names[v];
    for (int i = 0; i < s.len(); i++) begin
      idx = int'(s[i]) - int'("a");
      lit[idx] = 1'b1;
    end
    return active_low ? ~lit : lit;
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'h0, 7'b1000000};
    tbl[1]  = '{4'h1, 7'b1111001};
    tbl[2]  = '{4'h2, 7'b0100100};
    tbl[3]  = '{4'h3, 7'b0110000};
    tbl[4]  = '{4'h4, 7'b0011001};
    tbl[5]  = '{4'h5, 7'b0010010};
    tbl[6]  = '{4'h6, 7'b0000010};
    tbl[7]  = '{4'h7, 7'b1111000};
    tbl[8]  = '{4'h8, 7'b0000000};
    tbl[9]  = '{4'h9, 7'b0010000};
    tbl[10] = '{4'hA, 7'b0001000};
    tbl[11] = '{4'hB, 7'b0000011};
    tbl[12] = '{4'hC, 7'b1000110};
    tbl[13] = '{4'hD, 7'b0100001};
    tbl[14] = '{4'hE, 7'b0000110};
    tbl[15] = '{4'hF, 7'b0001110};

    rst = 1'b0;
    sw  = 4'h5;
    #1 rst = 1'b1;
    #1;
    check("reset_async", led, 7'b1111111);
    check("reset_async_hi", led_hi, 7'b0000000);
    tick();
    check("reset_held", led, 7'b1111111);

    @(negedge clk);
    sw  = 4'h0;
    rst = 1'b0;
    #1;
    check("release_before_edge", led, 7'b1111111);
    tick();
    check("release_first_edge", led, 7'b1000000);

    for (int i = 0; i < 16; i++) begin
      logic [6:0] prev;
      prev = led;
      @(negedge clk);
      sw = tbl[i].sw;
      #1;
      check($sformatf("walk_hold_%0h", i), led, prev);
      tick();
      check($sformatf("walk_%0h", i), led, tbl[i].exp);
      check($sformatf("walk_hi_%0h", i), led_hi, ~tbl[i].exp);
      check($sformatf("walk_model_%0h", i), led, model(tbl[i].sw, 1'b1));
    end

    @(negedge clk);
    sw = 4'h1;
    tick();
    check("mid_change_1", led, 7'b1111001);
    #2 sw = 4'h2;
    #1;
    check("mid_change_hold", led, 7'b1111001);
    tick();
    check("mid_change_2", led, 7'b0100100);

    @(negedge clk);
    sw = 4'h9;
    tick();
    check("pre_reset_9", led, 7'b0010000);
    #2 rst = 1'b1;
    #1;
    check("mid_reset_async", led, 7'b1111111);
    check("mid_reset_async_hi", led_hi, 7'b0000000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_reset_release_hold", led, 7'b1111111);
    tick();
    check("mid_reset_resume", led, 7'b0010000);

    @(negedge clk);
    sw = 4'h8;
    tick();
    check("active_high_8", led_hi, 7'b1111111);

    for (int n = 0; n < 300; n++) begin
      logic [3:0] v;
      bit r;
      @(negedge clk);
      v = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 19) == 0);
      sw  = v;
      rst = r;
      #1;
      if (r) begin
        check("rand_async_rst", led, 7'b1111111);
        check("rand_async_rst_hi", led_hi, 7'b0000000);
      end
      tick();
      check("rand_lo", led, r ? 7'b1111111 : model(v, 1'b1));
      check("rand_hi", led_hi, r ? 7'b0000000 : model(v, 1'b0));
    end
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
